arbitro_rr: RTL
===============

Name: arbitro_rr

Overview:
- Round-robin arbiter sharing one 8-way one-hot select resource (3-bit index + enable → 8 select lines) among 8 requesters.
- Registers the winner's index and enable, so they drive the 3-to-8 select stage directly; also provides the already-decoded one-hot grant.
- Enforces a maximum hold time per grant and rotates priority after every grant.

Parameters:
- N, 8, number of requesters. Fixed at 8; other values unsupported.
- IW, 3, index width, log2(N).
- MAX_HOLD, 16, maximum cycles a grant may be held (range 2..255).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- req  input  8  request vector; bit i = requester i wants the resource.
- rel  input  1  owner releases the resource; sampled only in GRANT.
- gnt  output 8  registered one-hot grant; all zeros when idle.
- idx  output 3  registered index of the current owner; feeds the select stage's address.
- en   output 1  registered grant-active flag; feeds the select stage's enable.
- tmo  output 1  one-cycle pulse when a grant is revoked by timeout.

Behaviour:
- Reset, active-high synchronous (rst=1 at a rising edge):
  - gnt=0, idx=0, en=0, tmo=0.
  - State=IDLE, priority pointer ptr=0, hold counter cnt=0.
  - rst overrides all other inputs.
  - Reset mid-grant drops en/gnt on that same edge; no tmo is generated.
- State IDLE:
  - If req==0: stay in IDLE; outputs unchanged (zero).
  - Else: winner w = first i with req[i]=1, searching ptr, ptr+1, … , 7, 0, … (mod 8).
  - On the edge: idx=w, gnt=1<<w, en=1, cnt=0, state→GRANT.
  - Latency: req asserted before edge k → gnt/en visible after edge k (1 cycle).
- State GRANT: each edge, evaluate in priority order:
  1. rel=1 or req[idx]=0 → release, tmo=0.
  2. Else if cnt==MAX_HOLD-1 → release, tmo=1 for exactly one cycle.
  3. Else → cnt=cnt+1, outputs held.
- Release (on the edge):
  - gnt=0, en=0; idx keeps its last value.
  - ptr=(idx+1) mod 8 (3-bit wrap: 7→0); cnt=0; state→IDLE.
- Spacing between grants:
  - At least one idle cycle (en=0) between consecutive grants.
  - Earliest next grant is 2 edges after the releasing edge's inputs were sampled.
- Hold limit: en stays high for at most MAX_HOLD consecutive cycles.
- Simultaneous events:
  - rel=1 on the timeout cycle → normal release, tmo stays 0.
  - Requests from non-owners during GRANT are ignored; they are evaluated in the next IDLE.
- Invariants:
  - gnt is zero or one-hot.
  - gnt == (en ? 1<<idx : 0) at all times.
  - tmo=1 implies en=0 in the same cycle.
- Widths:
  - ptr and idx are 3-bit with natural wrap.
  - cnt is 8-bit and compared for equality only; never exceeds MAX_HOLD-1.
- Structure: pure synchronous RTL, no latches; outputs are register outputs only.

Test Plan:
- Reset/idle: rst=1 for 2 cycles with req=8'hFF → gnt=0, en=0, idx=0, tmo=0. Release rst with req=8'h00 for 5 cycles → outputs stay 0.
- Single grant and release: after reset, req=8'h10 → next cycle gnt=8'h10, idx=4, en=1. rel=1 for one cycle → next cycle en=0, gnt=0. Keep req=8'h10 → grant to 4 returns after 1 idle cycle.
- Round-robin rotation: req=8'hFF held, rel pulsed each GRANT cycle → grant order idx=0,1,2,…,7,0 with one idle cycle between grants. Verifies 7→0 wrap.
- Skip and wrap: ptr=6 (after owner 5 released), req=8'h05 → grant idx=0 (not 2). After release, grant idx=2.
- Timeout: MAX_HOLD=16, req=8'h02 held, rel=0 → en high for exactly 16 cycles. tmo=1 on the cycle en falls, tmo=0 the next cycle. Bit 1 re-granted after the idle cycle.
- Corner cases:
  - rel=1 on cycle 16 of a hold → release with tmo=0.
  - Owner drops req mid-hold (req 8'h08→8'h00) → en=0 next cycle.
  - rst=1 mid-grant → en=0 and ptr=0. Next grant with req=8'h81 goes to idx=0.

Source files
------------

// File: rtl/arbitro_rr.sv
// Round-robin arbiter for 8 requesters sharing one 3-to-8 select stage.
// Registered idx/en/gnt, per-grant hold limit with timeout pulse, rotating priority.
module arbitro_rr #(
  parameter int N        = 8,
  parameter int IW       = 3,
  parameter int MAX_HOLD = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          rel,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          en,
  output logic          tmo
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(MAX_HOLD - 1);

  state_t        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic          en_q, en_d;
  logic          tmo_q, tmo_d;

  // Requests rotated so that bit 0 is the requester at the priority pointer.
  logic [N-1:0]  req_rot;
  logic [IW-1:0] win_off;
  logic [IW-1:0] win_idx;
  logic          any_req;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_rot
      assign req_rot[gi] = req[IW'(ptr_q + IW'(gi))];
    end
  endgenerate

  always_comb begin
    win_off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        win_off = IW'(i);
      end
    end
  end

  assign win_idx = IW'(ptr_q + win_off);
  assign any_req = |req;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    gnt_d   = gnt_q;
    en_d    = en_q;
    tmo_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          idx_d   = win_idx;
          gnt_d   = N'(1) << win_idx;
          en_d    = 1'b1;
          cnt_d   = '0;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (rel || !req[idx_q] || (cnt_q == CNT_LAST)) begin
          // A voluntary release always wins over a coincident timeout.
          tmo_d   = !(rel || !req[idx_q]);
          gnt_d   = '0;
          en_d    = 1'b0;
          ptr_d   = IW'(idx_q + IW'(1));
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      gnt_q   <= '0;
      en_q    <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
      en_q    <= en_d;
      tmo_q   <= tmo_d;
    end
  end

  assign gnt = gnt_q;
  assign idx = idx_q;
  assign en  = en_q;
  assign tmo = tmo_q;

endmodule
